line_buffer_ctrl: RTL
=====================

# line_buffer_ctrl

Controller and scheduler for the four line-buffer FIFOs that feed the 3x3 box-blur kernel. It steers the incoming pixel stream into the four buffers in round-robin line order. Once three full lines are resident, it reads those three lines in lockstep to present a column of three pixels per cycle to the kernel, while the fourth buffer keeps filling. It also raises a per-line completion pulse and a sticky overflow flag.

## Interface
- IMG_WIDTH, 16, pixels per image line (= line-buffer depth)
- DATA_WIDTH, 8, pixel width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- inPixel  input  DATA_WIDTH  incoming pixel
- inPixelValid  input  1  inPixel valid this cycle
- outReady  input  1  kernel can accept a pixel column this cycle
- inReady  output  1  controller can accept a pixel
- lbWrData  output  DATA_WIDTH  registered pixel to all line buffers
- lbWrValid  output  4  one-hot write strobe, bit k = buffer k
- lbRdEn  output  4  read strobe, three bits set while reading
- rdSel  output  2  index of the buffer holding the top kernel row
- kernelValid  output  1  read column valid, equal to |lbRdEn
- lineDone  output  1  one-cycle pulse when a line of columns is finished
- overflow  output  1  sticky: a pixel arrived while inReady was low

## Operation
- A pixel is accepted when `inPixelValid & inReady`. It is registered into lbWrData, and `lbWrValid = 1<<wrPtr` on the next cycle.
- wrCount counts 0..IMG_WIDTH-1 per accepted pixel. At IMG_WIDTH-1 it wraps to 0 and wrPtr increments mod 4.
- fillCount is the number of pixels resident and not yet consumed. Range is 0..4*IMG_WIDTH, width clog2(4*IMG_WIDTH+1).
  - Update each cycle: `fillCount += accept - topRead`, where topRead = 1 when a read strobe fires.
  - A simultaneous accept and topRead leaves fillCount unchanged.
- inReady = (fillCount < 4*IMG_WIDTH).
- A pixel arriving with inReady low is dropped. It sets overflow, which clears only on reset.
- Read FSM states:
  - IDLE: go to READ when fillCount >= 3*IMG_WIDTH.
  - READ: lbRdEn has bits rdPtr, rdPtr+1 and rdPtr+2 (mod 4) set in cycles where outReady = 1; otherwise lbRdEn = 0.
    - rdCount increments per strobe.
    - On the strobe with rdCount = IMG_WIDTH-1: rdCount goes to 0, rdPtr increments mod 4, lineDone pulses the next cycle, and the FSM returns to IDLE.
- rdSel = rdPtr, held constant for the whole line.
- The buffer at wrPtr never coincides with a buffer being read, except in the following case:
  - When fillCount reaches 4*IMG_WIDTH, wrPtr = rdPtr and writes stall.
  - Writes resume one cycle after the first top-row strobe frees a slot.

## Timing
- Reset values:
  - Outputs: inReady = 1; lbWrData, lbWrValid, lbRdEn and rdSel = 0; kernelValid, lineDone and overflow = 0.
  - Internal: state = IDLE; wrPtr, rdPtr, wrCount, rdCount and fillCount = 0.
- Write latency: an accept at edge N gives lbWrValid high for the cycle after edge N.
- Read start: the accept that makes fillCount = 3*IMG_WIDTH occurs at edge N. The FSM enters READ at edge N+1, and the first lbRdEn appears after edge N+1 if outReady is high.
- A stalled read holds rdCount, rdPtr and lbRdEn = 0. It resumes with no lost or repeated column.
- There is exactly one IDLE cycle between consecutive lines, even when fillCount >= 3*IMG_WIDTH.
- lbRdEn and kernelValid are combinational from state and outReady. All other outputs are registered.
- Asserting rst mid-line returns every output and counter to its reset value immediately. Partial lines are discarded.

## Test plan
- Reset, then stream 48 pixels (values 0..47) at 1 per cycle with outReady = 1:
  - lbWrValid walks 0001 for 16 cycles, then 0010, then 0100.
  - READ starts one cycle after the 48th accept; lbRdEn = 0111 for 16 cycles with rdSel = 0.
  - lineDone pulses once, and fillCount = 32 afterwards.
- Continuous stream of 112 pixels with outReady = 1:
  - Lines 2..4 are read with rdSel = 1, 2, 3, and lbRdEn = 1110, 1101 and 1011 respectively.
  - There is one IDLE cycle between lines; inReady never drops and overflow stays 0.
- outReady held low, stream 70 pixels:
  - inReady drops after the 64th accept, and pixels 65..70 set overflow.
  - Raising outReady gives lbRdEn = 0111 on the next cycle, and inReady returns one cycle after that.
- Toggle outReady every cycle during READ:
  - Exactly 16 strobes occur over 32 cycles with rdCount contiguous, and lineDone pulses once.
- Assert rst during the 8th read strobe of line 1:
  - All outputs go to reset values asynchronously.
  - After release, 48 new pixels are required before lbRdEn asserts again, with rdSel = 0.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// Write/read scheduler for the four line buffers feeding the 3x3 box-blur kernel.
// Pixels fill buffers round-robin; three resident lines are read in lockstep as pixel columns.
module line_buffer_ctrl #(
  parameter int IMG_WIDTH  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] inPixel,
  input  logic                  inPixelValid,
  input  logic                  outReady,
  output logic                  inReady,
  output logic [DATA_WIDTH-1:0] lbWrData,
  output logic [3:0]            lbWrValid,
  output logic [3:0]            lbRdEn,
  output logic [1:0]            rdSel,
  output logic                  kernelValid,
  output logic                  lineDone,
  output logic                  overflow
);

  localparam int FILL_W = $clog2(4*IMG_WIDTH+1);
  localparam int CNT_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(4*IMG_WIDTH);
  localparam logic [FILL_W-1:0] START_LVL = FILL_W'(3*IMG_WIDTH);
  localparam logic [CNT_W-1:0]  LAST_COL  = CNT_W'(IMG_WIDTH-1);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state;
  logic [1:0]        wrPtr;
  logic [1:0]        rdPtr;
  logic [CNT_W-1:0]  wrCount;
  logic [CNT_W-1:0]  rdCount;
  logic [FILL_W-1:0] fillCount;
  logic [FILL_W-1:0] fillNext;
  logic              accept;
  logic              topRead;

  // Three consecutive buffers starting at the top row, wrapping modulo 4.
  function automatic logic [3:0] readMask(input logic [1:0] top);
    logic [7:0] rot;
    rot = 8'h77 << top;
    return rot[7:4];
  endfunction

  always_comb begin
    accept      = inPixelValid & inReady;
    lbRdEn      = (state == READ && outReady) ? readMask(rdPtr) : 4'b0000;
    topRead     = |lbRdEn;
    kernelValid = topRead;
    fillNext    = fillCount + FILL_W'(accept) - FILL_W'(topRead);
  end

  assign rdSel = rdPtr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      wrCount   <= '0;
      rdCount   <= '0;
      fillCount <= '0;
      inReady   <= 1'b1;
      lbWrData  <= '0;
      lbWrValid <= '0;
      lineDone  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // write stage: register the accepted pixel and strobe the current buffer
      lbWrValid <= accept ? (4'b0001 << wrPtr) : 4'b0000;
      if (accept) begin
        lbWrData <= inPixel;
        if (wrCount == LAST_COL) begin
          wrCount <= '0;
          wrPtr   <= wrPtr + 2'd1;
        end else begin
          wrCount <= wrCount + CNT_W'(1);
        end
      end

      fillCount <= fillNext;
      inReady   <= (fillNext < FULL_LVL);
      if (inPixelValid && !inReady)
        overflow <= 1'b1;

      // read stage: one column per strobe; always drop to IDLE for one cycle between lines
      lineDone <= 1'b0;
      case (state)
        IDLE: begin
          if (fillCount >= START_LVL)
            state <= READ;
        end
        READ: begin
          if (topRead) begin
            if (rdCount == LAST_COL) begin
              rdCount  <= '0;
              rdPtr    <= rdPtr + 2'd1;
              lineDone <= 1'b1;
              state    <= IDLE;
            end else begin
              rdCount <= rdCount + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
